// File: rtl/cmp_pkg.sv
// Shared definitions for the branch-compare pipeline: compare-mode encodings,
// flag bit positions inside out_flags, and the mode and statistics widths.
package cmp_pkg;

  localparam int CMP_MODE_W = 3;
  localparam int CMP_FLAG_W = 5;
  localparam int CMP_CNT_W  = 32;

  typedef enum logic [CMP_MODE_W-1:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LTZ = 3'd2,
    CMP_LEZ = 3'd3,
    CMP_GTZ = 3'd4,
    CMP_GEZ = 3'd5,
    CMP_LT  = 3'd6,
    CMP_LTU = 3'd7
  } cmp_mode_e;

  // out_flags = {eq, lt_s, lt_u, a_zero, a_neg}
  localparam int FLAG_EQ     = 4;
  localparam int FLAG_LT_S   = 3;
  localparam int FLAG_LT_U   = 2;
  localparam int FLAG_A_ZERO = 1;
  localparam int FLAG_A_NEG  = 0;

endpackage

// File: rtl/cmp_eval.sv
// Combinational flag and condition evaluation for one operand pair.
// All flags are produced every cycle; mode only selects which condition drives taken.
module cmp_eval
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [CMP_MODE_W-1:0] mode,
  output logic                  taken,
  output logic [CMP_FLAG_W-1:0] flags
);

  logic eq;
  logic lt_s;
  logic lt_u;
  logic a_zero;
  logic a_neg;

  assign eq     = (a == b);
  // Signed compare on the full operands cannot overflow, unlike a subtract-and-test-sign.
  assign lt_s   = ($signed(a) < $signed(b));
  assign lt_u   = (a < b);
  assign a_zero = (a == '0);
  assign a_neg  = a[WIDTH-1];

  always_comb begin
    flags              = '0;
    flags[FLAG_EQ]     = eq;
    flags[FLAG_LT_S]   = lt_s;
    flags[FLAG_LT_U]   = lt_u;
    flags[FLAG_A_ZERO] = a_zero;
    flags[FLAG_A_NEG]  = a_neg;

    taken = 1'b0;
    case (cmp_mode_e'(mode))
      CMP_EQ:  taken = eq;
      CMP_NE:  taken = !eq;
      CMP_LTZ: taken = a_neg;
      CMP_LEZ: taken = a_neg || a_zero;
      CMP_GTZ: taken = !a_neg && !a_zero;
      CMP_GEZ: taken = !a_neg;
      CMP_LT:  taken = lt_s;
      CMP_LTU: taken = lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Two-stage branch-condition pipeline with a tag pass-through and flush.
// Optional taken-result counter compiled in with BRANCH_CMP_STATS_EN.
module branch_cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [CMP_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_taken,
  output logic [CMP_FLAG_W-1:0] out_flags,
  output logic [TAG_W-1:0]      out_tag,
  output logic [CMP_CNT_W-1:0]  taken_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and once raised the offered data holds
  // until the transfer. Both stages use pass-through ready.

  logic                  s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]      s1_a_q, s1_a_d;
  logic [WIDTH-1:0]      s1_b_q, s1_b_d;
  logic [CMP_MODE_W-1:0] s1_mode_q, s1_mode_d;
  logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;

  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_taken_q, s2_taken_d;
  logic [CMP_FLAG_W-1:0] s2_flags_q, s2_flags_d;
  logic [TAG_W-1:0]      s2_tag_q, s2_tag_d;

  logic                  s1_adv;
  logic                  s2_adv;
  logic                  accept;
  logic                  eval_taken;
  logic [CMP_FLAG_W-1:0] eval_flags;

  cmp_eval #(
    .WIDTH (WIDTH)
  ) u_eval (
    .a     (s1_a_q),
    .b     (s1_b_q),
    .mode  (s1_mode_q),
    .taken (eval_taken),
    .flags (eval_flags)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = !reset && !flush && s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_taken_d = s2_taken_q;
    s2_flags_d = s2_flags_q;
    s2_tag_d   = s2_tag_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_d = accept;
        if (accept) begin
          s1_a_d    = in_a;
          s1_b_d    = in_b;
          s1_mode_d = in_mode;
          s1_tag_d  = in_tag;
        end
      end
      // Output registers only change on a load, so a stalled result stays put.
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_taken_d = eval_taken;
          s2_flags_d = eval_flags;
          s2_tag_d   = s1_tag_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_taken_q <= 1'b0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_taken_q <= s2_taken_d;
      s2_flags_q <= s2_flags_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_taken = s2_taken_q;
  assign out_flags = s2_flags_q;
  assign out_tag   = s2_tag_q;

`ifdef BRANCH_CMP_STATS_EN
  logic [CMP_CNT_W-1:0] cnt_q, cnt_d;

  // A result consumed in the same cycle as a flush still counts: the consumer took it.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && out_taken && (cnt_q != {CMP_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Self-checking bench for branch_cmp_pipe: directed cases plus a random phase,
// with a scoreboard queue filled on accept and drained on result handshakes.
module tb_branch_cmp_pipe;
  import cmp_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int EW    = 1 + 5 + TAG_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [2:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_taken;
  logic [4:0]        out_flags;
  logic [TAG_W-1:0]  out_tag;
  logic [31:0]       taken_cnt;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_err    = 0;
  int            hs_total = 0;
  int            cnt_exp  = 0;
  logic          last_acc = 1'b0;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] held = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  branch_cmp_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_taken (out_taken),
    .out_flags (out_flags),
    .out_tag   (out_tag),
    .taken_cnt (taken_cnt)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] m, input logic [TAG_W-1:0] t);
    logic eq, lts, ltu, az, an, tk;
    eq  = (a == b);
    ltu = (a < b);
    an  = a[31];
    az  = (a == 32'd0);
    if (a[31] != b[31]) lts = a[31];
    else                lts = (a[30:0] < b[30:0]);
    case (m)
      3'd0:    tk = eq;
      3'd1:    tk = !eq;
      3'd2:    tk = an;
      3'd3:    tk = an || az;
      3'd4:    tk = !an && !az;
      3'd5:    tk = !an;
      3'd6:    tk = lts;
      default: tk = ltu;
    endcase
    return {tk, eq, lts, ltu, az, an, t};
  endfunction

  function automatic logic [31:0] cnt_expect();
`ifdef BRANCH_CMP_STATS_EN
    return cnt_exp;
`else
    return 32'd0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a falling edge with inputs set; samples mid-cycle, returns after the next falling edge.
  task automatic tick();
    logic [EW-1:0] e;
    #2;
    if (prev_stall) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_data", {out_taken, out_flags, out_tag}, held);
    end
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(model(in_a, in_b, in_mode, in_tag));
    if (out_valid && out_ready) begin
      hs_total++;
      check_eq("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("result", {out_taken, out_flags, out_tag}, e);
        if (e[EW-1]) cnt_exp++;
      end
    end
    if (reset || flush) exp_q.delete();
    if (reset) cnt_exp = 0;
    prev_stall = out_valid && !out_ready && !flush && !reset;
    held = {out_taken, out_flags, out_tag};
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                      input logic [TAG_W-1:0] t);
    int n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_mode = m; in_tag = t;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 40);
    check_eq("send_accept", last_acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    check_eq("drain_idle", out_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    int h0;
    logic [31:0] ta;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;
    @(negedge clk);
    repeat (2) tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_taken", out_taken, 0);
    check_eq("rst_out_flags", out_flags, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_taken_cnt", taken_cnt, 0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", in_ready, 1);

    // Signed LT with opposite signs, and two-cycle latency
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'd1; in_mode = 3'd6; in_tag = 5'd3;
    tick();
    check_eq("lat_accept", last_acc, 1);
    in_valid = 1'b0;
    check_eq("lat_c1_valid", out_valid, 0);
    tick();
    check_eq("lat_c2_valid", out_valid, 1);
    check_eq("lt_taken", out_taken, 1);
    check_eq("lt_s_flag", out_flags[FLAG_LT_S], 1);
    check_eq("lt_u_flag", out_flags[FLAG_LT_U], 0);
    drain();

    // Zero / sign boundaries
    send(32'd0, 32'd5, 3'd4, 5'd1);
    send(32'd0, 32'd5, 3'd5, 5'd2);
    send(32'h8000_0000, 32'd0, 3'd3, 5'd4);
    drain();

    // Eight back-to-back requests, one result per cycle
    h0 = hs_total;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      in_mode = 3'($urandom_range(0, 7)); in_tag = 5'(i);
      tick();
      check_eq("b2b_accept", last_acc, 1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("b2b_count", hs_total - h0, 8);
    drain();

    // Backpressure: 4 stalled cycles with 3 requests offered
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_a = 32'(idx * 7); in_b = 32'd7; in_mode = 3'd7; in_tag = 5'(10 + idx);
      tick();
      if (last_acc) idx++;
    end
    check_eq("bp_accepts", idx, 2);
    check_eq("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      in_valid = 1'b1; in_a = 32'(idx * 7); in_b = 32'd7; in_mode = 3'd7; in_tag = 5'(10 + idx);
      tick();
      if (last_acc) idx++;
    end
    check_eq("bp_all_sent", idx, 3);
    drain();

    // Flush with two requests in flight
    out_ready = 1'b0;
    send(32'd1, 32'd1, 3'd0, 5'd20);
    send(32'd2, 32'd1, 3'd1, 5'd21);
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd3; in_b = 32'd3; in_mode = 3'd0; in_tag = 5'd22;
    #1;
    check_eq("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_eq("flush_c1_valid", out_valid, 0);
    tick();
    check_eq("flush_c2_valid", out_valid, 0);
    send(32'd5, 32'd6, 3'd6, 5'd9);
    tick();
    check_eq("flush_next_valid", out_valid, 1);
    check_eq("flush_next_tag", out_tag, 9);
    drain();

    // Random traffic with random backpressure and occasional flush
    for (int c = 0; c < 80; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      ta        = $urandom;
      in_a      = ($urandom_range(0, 3) == 0) ? 32'd0 : ta;
      in_b      = ($urandom_range(0, 3) == 0) ? ta : $urandom;
      in_mode   = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom_range(0, 31));
      tick();
    end
    flush = 1'b0;
    drain();

    // Statistics: 5 taken and 3 not-taken after a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("stats_rst_cnt", taken_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      ta = $urandom;
      if (i == 1 || i == 4 || i == 6) send(ta, ta + 32'd1, 3'd0, 5'(i));
      else                            send(ta, ta, 3'd0, 5'(i));
    end
    drain();
`ifdef BRANCH_CMP_STATS_EN
    check_eq("stats_cnt5", taken_cnt, 5);
`else
    check_eq("stats_cnt_off", taken_cnt, 0);
`endif

    // Reset mid-stream
    send(32'd4, 32'd4, 3'd0, 5'd1);
    send(32'd4, 32'd4, 3'd0, 5'd2);
    reset = 1'b1;
    tick();
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_cnt", taken_cnt, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    tick();
    check_eq("midrst_still_idle", out_valid, 0);
    reset = 1'b0;
    #1;
    check_eq("midrst_ready_back", in_ready, 1);
    send(32'hFFFF_FFF0, 32'd0, 3'd2, 5'd17);
    drain();
    check_eq("final_cnt", taken_cnt, cnt_expect());

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_cmp_pipe.md
BRANCH_CMP_PIPE -- requirements
Module: branch_cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal values 8..64).
REQ-002 SHALL have parameter TAG_W, default 5, width of the pass-through tag (destination or ID).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1) for the request handshake.
REQ-006 SHALL have ports in_a and in_b, input, WIDTH, the two operands.
REQ-007 SHALL have port in_mode, input, 3, the compare mode; in_tag, input, TAG_W, opaque tag.
REQ-008 SHALL have port flush, input, 1, which discards all in-flight requests.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1) for the result handshake.
REQ-010 SHALL have port out_taken, output, 1, the condition result for the requested mode.
REQ-011 SHALL have port out_flags, output, 5, {eq, lt_s, lt_u, a_zero, a_neg}, always computed regardless of mode.
REQ-012 SHALL have port out_tag, output, TAG_W, the tag of the request, returned unchanged.
REQ-013 SHALL have port taken_cnt, output, 32, the taken-result statistics counter.

Function
REQ-014 SHALL decode modes as 0 EQ(a==b), 1 NE, 2 LTZ(a<0), 3 LEZ(a<=0), 4 GTZ(a>0), 5 GEZ(a>=0), 6 LT(signed a<b), 7 LTU(unsigned a<b).
REQ-015 SHALL treat a value as negative when its bit WIDTH-1 is set; LTZ/LEZ/GTZ/GEZ SHALL ignore in_b.
REQ-016 SHALL be a two-stage pipeline: S1 registers operands, mode and tag; S2 registers out_taken, out_flags and out_tag.
REQ-017 SHALL accept a request when in_valid && in_ready, and SHALL present its result with out_valid high exactly 2 cycles later when there is no backpressure.
REQ-018 SHALL advance each stage when it is empty or the stage downstream of it advances; in_ready = !S1_valid || S1 advances (pass-through ready, with no combinational path from in_valid).
REQ-019 SHALL hold out_valid, out_taken, out_flags and out_tag stable while out_valid && !out_ready.
REQ-020 SHALL sustain one result per cycle with out_ready held high, and SHALL lose no request and duplicate no request under any out_ready pattern.
REQ-021 SHALL compute lt_s as the full signed comparison, without overflow error when the operands have opposite signs.
REQ-022 SHALL, when flush is high, clear both stage valid bits at the clock edge, drive in_ready low for that cycle, and drop any request offered in that cycle.
REQ-023 SHALL give flush priority over acceptance and advancement; reset SHALL have priority over flush.
REQ-024 SHALL increment taken_cnt by 1 on every result handshake (out_valid && out_ready) where out_taken=1, saturating at 0xFFFFFFFF.

Reset
REQ-025 SHALL, while reset is high at a clock edge, clear S1/S2 valid bits and drive out_valid=0, out_taken=0, out_flags=0, out_tag=0, taken_cnt=0, and in_ready=0.
REQ-026 SHALL drive in_ready=1 on the first cycle after reset deasserts; reset asserted mid-operation SHALL discard all in-flight requests.

Configuration
REQ-027 SHALL compile taken_cnt logic only when macro BRANCH_CMP_STATS_EN is defined; when it is undefined, taken_cnt SHALL be constant 0 and hold no registers.

Structure
REQ-028 SHALL place the mode encodings (CMP_EQ..CMP_LTU), the flag bit indices and the mode width constant in the shared package cmp_pkg.
REQ-029 SHALL isolate the combinational flag/condition evaluation in sub-module cmp_eval (WIDTH parameter; inputs a, b, mode; outputs taken, flags), instantiated between S1 and S2.

Verification
REQ-030 SHALL cover: WIDTH=32, mode LT, a=0xFFFFFFFF, b=1 -> out_taken=1, lt_s=1, lt_u=0, valid 2 cycles after accept.
REQ-031 SHALL cover: mode GTZ, a=0 -> out_taken=0, a_zero=1; mode GEZ, a=0 -> out_taken=1; mode LEZ, a=0x80000000 -> out_taken=1, a_neg=1.
REQ-032 SHALL cover: 8 back-to-back requests with tags 0..7 and out_ready=1 -> 8 results in consecutive cycles, tags in order 0..7.
REQ-033 SHALL cover: out_ready low for 4 cycles with 3 requests offered -> in_ready low after 2 accepts, outputs stable, all 3 delivered in order once out_ready rises.
REQ-034 SHALL cover: flush asserted with 2 requests in flight -> no out_valid in the next 2 cycles, and the next request (tag 9) is returned with tag 9.
REQ-035 SHALL cover: with BRANCH_CMP_STATS_EN defined, 5 taken and 3 not-taken results -> taken_cnt=5; reset mid-stream -> taken_cnt=0 and out_valid=0.
